// File: rtl/digit_scan_mux.sv
// digit_scan_mux
//   Time-multiplexed scanner for a 4-digit 7-segment display. A prescaler
//   holds each digit active for SCAN_DIV clocks. A 2-bit digit index then
//   selects the next digit. A new value is double-buffered through a pending
//   register and reaches the display register only at a frame boundary. This
//   means a frame never shows a mix of old and new digits.
//
//   Optional build macro: DIGIT_SCAN_LEADING_ZERO_BLANK_EN
//     When defined, digits 1..3 are blanked when they and every higher digit
//     are zero. Digit0 is never blanked.
//     When undefined, blank is always 0 and num is always the raw nibble.
//
// Parameters
//   SCAN_DIV    clocks each digit stays active (2..65535)
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        request to take a new display value
//   value       four BCD digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   ready       high when a load would be accepted this cycle
//   num         code of the active digit (4'hF while blanked)
//   dig_sel     one-hot active-high digit enable
//   blank       active digit is suppressed
//   frame_tick  one-cycle pulse on the last clock of each 4-digit scan
//
// Handshake: a load transfers on any rising edge where load=1 and ready=1.
// ready is low only while a value waits in the pending register, and a
// load seen while ready=0 is dropped without effect.

module digit_scan_mux #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   output logic        ready,
   output logic [3:0]  num,
   output logic [3:0]  dig_sel,
   output logic        blank,
   output logic        frame_tick
);

   localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

   logic [15:0] presc;
   logic [1:0]  index;
   logic [15:0] display;
   logic [15:0] pending;
   logic        pending_valid;

   logic        presc_last;
   logic        load_acc;
   logic [3:0]  raw_num;

   assign presc_last = (presc == PRESC_MAX);
   assign frame_tick = presc_last && (index == 2'd3);
   assign ready      = !pending_valid;
   assign load_acc   = load && ready;

   // Scan timing: the prescaler wraps, and the digit index advances on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         index <= '0;
      end else if (presc_last) begin
         presc <= '0;
         index <= index + 2'd1;
      end else begin
         presc <= presc + 16'd1;
      end
   end

   // Double buffer. The display register changes only on the edge that ends
   // a frame_tick cycle. At that edge it takes the pending value if there is
   // one. Otherwise it takes a load accepted in that same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display       <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
      end else if (frame_tick) begin
         if (pending_valid) begin
            display       <= pending;
            pending_valid <= 1'b0;
         end else if (load_acc) begin
            display <= value;
         end
      end else if (load_acc) begin
         pending       <= value;
         pending_valid <= 1'b1;
      end
   end

   always_comb begin
      dig_sel = 4'b0001 << index;
      case (index)
         2'd0:    raw_num = display[3:0];
         2'd1:    raw_num = display[7:4];
         2'd2:    raw_num = display[11:8];
         default: raw_num = display[15:12];
      endcase
   end

`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every digit above it are zero.
   always_comb begin
      case (index)
         2'd0:    blank = 1'b0;
         2'd1:    blank = (display[15:4] == 12'h000);
         2'd2:    blank = (display[15:8] == 8'h00);
         default: blank = (display[15:12] == 4'h0);
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   // 4'hF tells the segment decoder to turn every segment off.
   assign num = blank ? 4'hF : raw_num;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux
//   Directed bench for digit_scan_mux with SCAN_DIV=4. The variable k counts
//   clock edges since the most recent reset release. At sample point k the
//   prescaler is k%4 and the digit index is (k/4)%4. All expected values
//   below are worked out by hand from that timeline.

module tb_digit_scan_mux;

   localparam int SCAN_DIV = 4;

`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic        ready;
   logic [3:0]  num;
   logic [3:0]  dig_sel;
   logic        blank;
   logic        frame_tick;

   int n_checks;
   int n_errors;
   int k;

   digit_scan_mux #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .value      (value),
      .ready      (ready),
      .num        (num),
      .dig_sel    (dig_sel),
      .blank      (blank),
      .frame_tick (frame_tick)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic run_to(input int t);
      while (k < t) tick();
   endtask

   // checking
   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s k=%0d got %h exp %h", tag, k, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      k        = 0;
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0000;

      // reset values while held in reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",   16'(ready),      16'h1);
      check("rst_dig_sel", 16'(dig_sel),    16'h1);
      check("rst_num",     16'(num),        16'h0);
      check("rst_blank",   16'(blank),      16'h0);
      check("rst_tick",    16'(frame_tick), 16'h0);

      rst_n = 1'b1;
      k = 0;

      // first frame, no load: each digit is held 4 clocks, with one tick per 16 clocks
      for (int i = 0; i < 16; i++) begin
         run_to(i);
         check("scan_sel",   16'(dig_sel),    16'(4'b0001 << (i / 4)));
         check("scan_tick",  16'(frame_tick), 16'((i == 15) ? 1 : 0));
         check("scan_num",   16'(num),        16'((LZB && i >= 4) ? 4'hF : 4'h0));
         check("scan_blank", 16'(blank),      16'((LZB && i >= 4) ? 1 : 0));
      end

      // load 1234 at scan start; it is pending until the frame_tick edge
      run_to(16);
      check("l1234_rdy0", 16'(ready), 16'h1);
      load = 1'b1; value = 16'h1234;
      tick();
      load = 1'b0;
      check("l1234_busy", 16'(ready), 16'h0);
      check("l1234_old",  16'(num),   16'h0);
      run_to(31);
      check("l1234_tick", 16'(frame_tick), 16'h1);
      check("l1234_wait", 16'(ready),      16'h0);
      tick();
      check("l1234_rdy1", 16'(ready),   16'h1);
      check("l1234_d0s",  16'(dig_sel), 16'h1);
      check("l1234_d0",   16'(num),     16'h4);
      run_to(36); check("l1234_d1", 16'(num), 16'h3);
      run_to(40); check("l1234_d2", 16'(num), 16'h2);
      run_to(44); check("l1234_d3", 16'(num), 16'h1);

      // load 5678 in the frame_tick cycle with nothing pending: it is displayed directly
      run_to(47);
      check("l5678_tick", 16'(frame_tick), 16'h1);
      check("l5678_rdy",  16'(ready),      16'h1);
      load = 1'b1; value = 16'h5678;
      tick();
      load = 1'b0;
      check("l5678_d0",   16'(num),   16'h8);
      check("l5678_rdy1", 16'(ready), 16'h1);
      run_to(52); check("l5678_d1", 16'(num), 16'h7);

      // load 1111, then 2222 while busy: 2222 must be dropped
      load = 1'b1; value = 16'h1111;
      tick();
      check("l1111_busy", 16'(ready), 16'h0);
      value = 16'h2222;
      run_to(56);
      load = 1'b0;
      check("l1111_old", 16'(num),   16'h6);
      check("l2222_ign", 16'(ready), 16'h0);
      run_to(64);
      check("l1111_d0",  16'(num),   16'h1);
      check("l1111_rdy", 16'(ready), 16'h1);

      // non-BCD nibbles pass through unchanged
      load = 1'b1; value = 16'hFEDA;
      tick();
      load = 1'b0;
      run_to(68); check("l1111_d1", 16'(num), 16'h1);
      run_to(80); check("hex_d0",   16'(num), 16'hA);
      run_to(84); check("hex_d1",   16'(num), 16'hD);
      check("hex_blank", 16'(blank), 16'h0);

      // reset mid-frame with 9999 pending
      run_to(86);
      load = 1'b1; value = 16'h9999;
      tick();
      load = 1'b0;
      check("p9999_busy", 16'(ready), 16'h0);
      tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 16'(ready),      16'h1);
      check("mid_rst_sel",   16'(dig_sel),    16'h1);
      check("mid_rst_num",   16'(num),        16'h0);
      check("mid_rst_blank", 16'(blank),      16'h0);
      check("mid_rst_tick",  16'(frame_tick), 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      k = 0;
      check("rel_sel",   16'(dig_sel), 16'h1);
      check("rel_ready", 16'(ready),   16'h1);
      run_to(3);  check("rel_sel3", 16'(dig_sel), 16'h1);
      run_to(4);  check("rel_sel4", 16'(dig_sel), 16'h2);
      run_to(16);
      check("rel_disc",   16'(num),   16'h0);
      check("rel_ready2", 16'(ready), 16'h1);

      // leading-zero blanking (blank stays 0 when the feature is off)
      load = 1'b1; value = 16'h0042;
      tick();
      load = 1'b0;
      run_to(32);
      check("z42_d0",  16'(num),   16'h2);
      check("z42_b0",  16'(blank), 16'h0);
      load = 1'b1; value = 16'h0000;
      tick();
      load = 1'b0;
      run_to(36);
      check("z42_d1",  16'(num),   16'h4);
      check("z42_b1",  16'(blank), 16'h0);
      run_to(40);
      check("z42_d2",  16'(num),   LZB ? 16'hF : 16'h0);
      check("z42_b2",  16'(blank), LZB ? 16'h1 : 16'h0);
      run_to(44);
      check("z42_d3",  16'(num),   LZB ? 16'hF : 16'h0);
      check("z42_b3",  16'(blank), LZB ? 16'h1 : 16'h0);
      run_to(48);
      check("z00_d0",  16'(num),   16'h0);
      check("z00_b0",  16'(blank), 16'h0);
      run_to(52);
      check("z00_d1",  16'(num),   LZB ? 16'hF : 16'h0);
      check("z00_b1",  16'(blank), LZB ? 16'h1 : 16'h0);
      run_to(60);
      check("z00_d3",  16'(num),   LZB ? 16'hF : 16'h0);
      check("z00_b3",  16'(blank), LZB ? 16'h1 : 16'h0);

      // report
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
